heichips_mem_arbiter: RTL

Shares the single off-chip memory link (the nibble serializer) between the Snitch instruction port (read-only) and data port (read/write). Arbitrates one transaction at a time, registers the winning request, drives the serializer's 32-bit request interface and routes the returned word back to the right requester. Sits between i_snitch and the 32-to-4-bit serializer in heichips25_template.

---
 rtl/heichips_mem_pkg.sv | 43 ++++
 rtl/heichips_rr_arb2.sv | 28 ++
 rtl/heichips_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/heichips_mem_pkg.sv
// Shared types and constants for the Snitch-to-serializer memory arbiter.
// Holds the FSM state, grant encoding, captured request payload and the tie-break helper.
package heichips_mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [DATA_W-1:0] DEADBEEF = DATA_W'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2,
      DLV  = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_INST = 1'b0,
      GNT_DATA = 1'b1
   } grant_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] strb;
   } mem_req_t;

   // req[1] = data port, req[0] = inst port; a lone requester always wins
   function automatic grant_e pick2(input logic [1:0] req, input logic prio, input grant_e last);
      grant_e g;
      g = GNT_INST;
      if (req == 2'b11) begin
         if (prio) g = GNT_DATA;
         else      g = (last == GNT_INST) ? GNT_DATA : GNT_INST;
      end else if (req[1]) begin
         g = GNT_DATA;
      end
      return g;
   endfunction

endpackage

// File: rtl/heichips_rr_arb2.sv
// Two-way round-robin picker between the instruction and data ports.
// The last-grant register resets to data so the instruction port wins the first tie.
module heichips_rr_arb2
   import heichips_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       update,
   output grant_e     grant_c
);

   grant_e last_q;

   always_comb begin
      grant_c = pick2(req, prio, last_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= GNT_DATA;
      end else if (update) begin
         last_q <= grant_c;
      end
   end

endmodule

// File: rtl/heichips_mem_arbiter.sv
// Arbitrates the single off-chip memory link between Snitch inst and data ports.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module heichips_mem_arbiter
   import heichips_mem_pkg::*;
#(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter logic        DataPrio      = 1'b0,
   parameter int unsigned TimeoutCycles = 255,
   localparam int unsigned StrbWidth    = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] inst_addr_i,
   input  logic                 inst_valid_i,
   output logic                 inst_ready_o,
   output logic [DataWidth-1:0] inst_data_o,
   input  logic [AddrWidth-1:0] data_qaddr_i,
   input  logic                 data_qwrite_i,
   input  logic [DataWidth-1:0] data_qdata_i,
   input  logic [StrbWidth-1:0] data_qstrb_i,
   input  logic                 data_qvalid_i,
   output logic                 data_qready_o,
   output logic [DataWidth-1:0] data_pdata_o,
   output logic                 data_pvalid_o,
   input  logic                 data_pready_i,
   output logic [AddrWidth-1:0] mem_req_addr_o,
   output logic                 mem_req_write_o,
   output logic [DataWidth-1:0] mem_req_wdata_o,
   output logic [StrbWidth-1:0] mem_req_strb_o,
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   input  logic [DataWidth-1:0] mem_rsp_rdata_i,
   input  logic                 mem_rsp_valid_i,
   output logic                 mem_rsp_ready_o,
   output logic                 busy_o,
   output logic                 grant_o,
   output logic                 err_o
);

   arb_state_e           state;
   grant_e               grant_q;
   grant_e               gnt_c;
   mem_req_t             req_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 take_c;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   logic [CntW-1:0] cnt_q;
`else
   assign err_o = 1'b0;
`endif

   assign take_c = (state == IDLE) && (inst_valid_i || data_qvalid_i);

   heichips_rr_arb2 u_arb (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .req     ({data_qvalid_i, inst_valid_i}),
      .prio    (DataPrio),
      .update  (take_c),
      .grant_c (gnt_c)
   );

   // Handshake acks depend on live inputs: data is acked as it is captured, inst only while still requested
   assign data_qready_o = take_c && (gnt_c == GNT_DATA);
   assign inst_ready_o  = (state == DLV) && (grant_q == GNT_INST) && inst_valid_i;

   assign inst_data_o     = rdata_q;
   assign data_pdata_o    = rdata_q;
   assign grant_o         = grant_q;
   assign mem_req_addr_o  = AddrWidth'(req_q.addr);
   assign mem_req_write_o = req_q.write;
   assign mem_req_wdata_o = DataWidth'(req_q.wdata);
   assign mem_req_strb_o  = StrbWidth'(req_q.strb);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= IDLE;
         grant_q         <= GNT_INST;
         req_q           <= '0;
         rdata_q         <= '0;
         mem_req_valid_o <= 1'b0;
         mem_rsp_ready_o <= 1'b0;
         data_pvalid_o   <= 1'b0;
         busy_o          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         err_o           <= 1'b0;
         cnt_q           <= '0;
`endif
      end else begin
`ifdef MEM_ARB_TIMEOUT_EN
         err_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (take_c) begin
                  grant_q <= gnt_c;
                  if (gnt_c == GNT_DATA) begin
                     req_q <= '{addr:  ADDR_W'(data_qaddr_i),
                                write: data_qwrite_i,
                                wdata: DATA_W'(data_qdata_i),
                                strb:  STRB_W'(data_qstrb_i)};
                  end else begin
                     req_q <= '{addr:  ADDR_W'(inst_addr_i),
                                write: 1'b0,
                                wdata: '0,
                                strb:  '0};
                  end
                  state           <= REQ;
                  mem_req_valid_o <= 1'b1;
                  busy_o          <= 1'b1;
               end
            end
            // Stores retire at the downstream handshake; loads and fetches wait for data
            REQ: begin
               if (mem_req_ready_i) begin
                  mem_req_valid_o <= 1'b0;
                  if (req_q.write) begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     state           <= RSP;
                     mem_rsp_ready_o <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                     cnt_q           <= '0;
`endif
                  end
               end
            end
            RSP: begin
               if (mem_rsp_valid_i) begin
                  rdata_q         <= mem_rsp_rdata_i;
                  mem_rsp_ready_o <= 1'b0;
                  data_pvalid_o   <= (grant_q == GNT_DATA);
                  state           <= DLV;
`ifdef MEM_ARB_TIMEOUT_EN
               end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                  rdata_q         <= DataWidth'(DEADBEEF);
                  err_o           <= 1'b1;
                  mem_rsp_ready_o <= 1'b0;
                  data_pvalid_o   <= (grant_q == GNT_DATA);
                  state           <= DLV;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
`endif
               end
            end
            DLV: begin
               if (grant_q == GNT_INST) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (data_pready_i) begin
                  data_pvalid_o <= 1'b0;
                  state         <= IDLE;
                  busy_o        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
